clk_source_supervisor: RTL and testbench

Successor to the fixed two-input HDMI/local clock mux. Runs on the local on-board clock and measures the edge rate of NUM_SRC candidate clock sources, each supplied as a divided toggle signal. It rejects dead or "ghost" (slowed, cable-less) clocks through a min/max rate window with qualification hysteresis. It drives the select index for the downstream BUFGMUX tree, with a glitch-safe switch sequence and a switching flag that downstream logic uses to hold video pipelines in reset.

---
 rtl/clk_source_supervisor_if.sv | 24 ++
 rtl/clk_source_supervisor.sv | 147 ++++++++++++++
 tb/tb_clk_source_supervisor.sv | 174 +++++++++++++++++
 3 files changed

// File: rtl/clk_source_supervisor_if.sv
// Signal bundle between the clock-source supervisor and its environment.
// The slave side belongs to the supervisor. The master side drives the toggles and the force controls.
interface clk_source_supervisor_if #(
    parameter int NUM_SRC = 2,
    parameter int SEL_W   = 1
);
    logic [NUM_SRC-1:0] src_toggle;
    logic               force_en;
    logic [SEL_W-1:0]   force_sel;
    logic [SEL_W-1:0]   sel_idx;
    logic               online;
    logic [NUM_SRC-1:0] src_valid;
    logic               switching;

    modport master (
        output src_toggle, force_en, force_sel,
        input  sel_idx, online, src_valid, switching
    );

    modport slave (
        input  src_toggle, force_en, force_sel,
        output sel_idx, online, src_valid, switching
    );
endinterface

// File: rtl/clk_source_supervisor.sv
// Qualifies candidate clock sources by edge rate over fixed windows of the local clock.
// Drives a glitch-safe select index (quiesce, switch, settle) to the downstream clock-mux tree.
module clk_source_supervisor #(
    parameter int NUM_SRC       = 2,
    parameter int SEL_W         = 1,
    parameter int WIN_CYCLES    = 65536,
    parameter int CNT_W         = 16,
    parameter int MIN_EDGES     = 8000,
    parameter int MAX_EDGES     = 12000,
    parameter int GOOD_WINDOWS  = 4,
    parameter int SETTLE_CYCLES = 256
) (
    input logic                    clk,
    input logic                    rst,
    clk_source_supervisor_if.slave bus
);
    localparam int WIN_W       = (WIN_CYCLES > 2) ? $clog2(WIN_CYCLES) : 1;
    localparam int GOOD_W      = $clog2(GOOD_WINDOWS + 1);
    localparam int PH_W        = (SETTLE_CYCLES > 2) ? $clog2(SETTLE_CYCLES) : 1;
    localparam int VALID_EXT_W = 1 << SEL_W;

    localparam logic [WIN_W-1:0]  WIN_LAST    = WIN_W'(WIN_CYCLES - 1);
    localparam logic [CNT_W-1:0]  CNT_MAX     = {CNT_W{1'b1}};
    localparam logic [CNT_W-1:0]  MIN_C       = CNT_W'(MIN_EDGES);
    localparam logic [CNT_W-1:0]  MAX_C       = CNT_W'(MAX_EDGES);
    localparam logic [GOOD_W-1:0] GOOD_C      = GOOD_W'(GOOD_WINDOWS);
    localparam logic [PH_W-1:0]   SETTLE_LAST = PH_W'(SETTLE_CYCLES - 1);

    typedef enum logic [1:0] {STABLE, QUIESCE, SETTLE} state_t;

    logic [NUM_SRC-1:0] src_in, sync1, sync2, sync3, edge_seen;
    logic [NUM_SRC-1:0] valid_q, win_good;
    logic [CNT_W-1:0]   edge_cnt [NUM_SRC];
    logic [CNT_W-1:0]   cnt_next [NUM_SRC];
    logic [GOOD_W-1:0]  good_cnt [NUM_SRC];
    logic [GOOD_W-1:0]  good_inc [NUM_SRC];
    logic [WIN_W-1:0]   win_cnt;
    logic               win_end;

    logic [VALID_EXT_W-1:0] valid_ext;
    logic [SEL_W-1:0]       target, sel_q;
    logic                   online_q, load_sel;
    state_t                 state, state_next;
    logic [PH_W-1:0]        phase, phase_next;
    logic                   unused_src0;

    // Lane 0 is the local fallback: its toggle is never measured.
    assign src_in      = {bus.src_toggle[NUM_SRC-1:1], 1'b0};
    assign unused_src0 = bus.src_toggle[0];
    assign edge_seen   = sync2 ^ sync3;
    assign win_end     = (win_cnt == WIN_LAST);

    // NOTE: every variable gets a default first so no path leaves it unassigned (no latch).
    always_comb begin
        for (int i = 0; i < NUM_SRC; i++) begin
            cnt_next[i] = edge_cnt[i];
            if (edge_seen[i] && edge_cnt[i] != CNT_MAX)
                cnt_next[i] = edge_cnt[i] + 1'b1;
            win_good[i] = (cnt_next[i] >= MIN_C) && (cnt_next[i] <= MAX_C);
            good_inc[i] = (good_cnt[i] == GOOD_C) ? GOOD_C : good_cnt[i] + 1'b1;
        end
    end

    // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            sync1   <= '0;
            sync2   <= '0;
            sync3   <= '0;
            win_cnt <= '0;
            valid_q <= NUM_SRC'(1);
            for (int i = 0; i < NUM_SRC; i++) begin
                edge_cnt[i] <= '0;
                good_cnt[i] <= '0;
            end
        end else begin
            sync1   <= src_in;
            sync2   <= sync1;
            sync3   <= sync2;
            win_cnt <= win_end ? '0 : win_cnt + 1'b1;
            for (int i = 0; i < NUM_SRC; i++) begin
                edge_cnt[i] <= win_end ? '0 : cnt_next[i];
                if (win_end && i != 0) begin
                    good_cnt[i] <= win_good[i] ? good_inc[i] : '0;
                    valid_q[i]  <= win_good[i] && (good_inc[i] == GOOD_C);
                end
            end
        end
    end

    // Zero padding makes out-of-range force indices read as unqualified, so they fall back to 0.
    assign valid_ext = VALID_EXT_W'(valid_q);

    always_comb begin
        target = '0;
        if (bus.force_en) begin
            if (valid_ext[bus.force_sel])
                target = bus.force_sel;
        end else begin
            for (int i = 1; i < NUM_SRC; i++)
                if (valid_q[i]) target = SEL_W'(i);
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state    <= STABLE;
            phase    <= '0;
            sel_q    <= '0;
            online_q <= 1'b0;
        end else begin
            state <= state_next;
            phase <= phase_next;
            if (load_sel) begin
                sel_q    <= target;
                online_q <= (target != '0);
            end
        end
    end

    always_comb begin
        state_next = state;
        phase_next = '0;
        load_sel   = 1'b0;
        case (state)
            STABLE:  if (target != sel_q) state_next = QUIESCE;
            QUIESCE: begin
                if (phase == PH_W'(1)) begin
                    load_sel   = 1'b1;
                    state_next = SETTLE;
                end else begin
                    phase_next = phase + 1'b1;
                end
            end
            SETTLE: begin
                if (phase == SETTLE_LAST) state_next = STABLE;
                else                      phase_next = phase + 1'b1;
            end
            default: state_next = STABLE;
        endcase
    end

    assign bus.sel_idx   = sel_q;
    assign bus.online    = online_q;
    assign bus.src_valid = valid_q;
    assign bus.switching = (state != STABLE);
endmodule

// File: tb/tb_clk_source_supervisor.sv
// Directed bench for clk_source_supervisor. Windows are driven cycle-exact from reset release.
// CNT_W=6 makes saturation observable: a wrapping counter would fold 98 edges into the good band.
`timescale 1ns/1ps
module tb_clk_source_supervisor;
    localparam int NUM_SRC       = 2;
    localparam int SEL_W         = 2;
    localparam int WIN_CYCLES    = 100;
    localparam int CNT_W         = 6;
    localparam int MIN_EDGES     = 20;
    localparam int MAX_EDGES     = 40;
    localparam int GOOD_WINDOWS  = 3;
    localparam int SETTLE_CYCLES = 8;

    logic clk = 1'b0;
    logic rst;
    int   vectors = 0;
    int   miscompares = 0;
    int   sw_cycles = 0;

    clk_source_supervisor_if #(.NUM_SRC(NUM_SRC), .SEL_W(SEL_W)) bus ();

    clk_source_supervisor #(
        .NUM_SRC(NUM_SRC), .SEL_W(SEL_W), .WIN_CYCLES(WIN_CYCLES), .CNT_W(CNT_W),
        .MIN_EDGES(MIN_EDGES), .MAX_EDGES(MAX_EDGES), .GOOD_WINDOWS(GOOD_WINDOWS),
        .SETTLE_CYCLES(SETTLE_CYCLES)
    ) dut (
        .clk(clk),
        .rst(rst),
        .bus(bus)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // One clk cycle: optional toggle of source 1, count switching, advance to the next negedge.
    task automatic tick(input bit tog);
        if (tog) bus.src_toggle[1] = ~bus.src_toggle[1];
        if (bus.switching) sw_cycles++;
        @(negedge clk);
    endtask

    task automatic run_win(input int n_edges);
        for (int i = 0; i < WIN_CYCLES; i++) tick(i < n_edges);
    endtask

    initial begin
        bus.src_toggle = '0;
        bus.force_en   = 1'b0;
        bus.force_sel  = '0;
        rst            = 1'b1;
        repeat (3) @(negedge clk);
        check("rst_sel",    32'(bus.sel_idx),   32'd0);
        check("rst_online", 32'(bus.online),    32'd0);
        check("rst_switch", 32'(bus.switching), 32'd0);
        check("rst_valid",  32'(bus.src_valid), 32'h1);
        rst = 1'b0;

        // Ghost clock: 10 edges per window never qualifies.
        sw_cycles = 0;
        repeat (10) run_win(10);
        check("ghost_valid",  32'(bus.src_valid), 32'h1);
        check("ghost_sel",    32'(bus.sel_idx),   32'd0);
        check("ghost_switch", 32'(sw_cycles),     32'd0);

        // Bring-up: 30 edges per window; valid after the third good window.
        run_win(30);
        run_win(30);
        check("bring_2win_valid", 32'(bus.src_valid), 32'h1);
        run_win(30);
        check("bring_valid",     32'(bus.src_valid), 32'h3);
        check("bring_sw_idle",   32'(bus.switching), 32'd0);
        for (int i = 0; i < WIN_CYCLES; i++) begin
            if (i == 1) begin
                check("bring_sw_rise", 32'(bus.switching), 32'd1);
                check("bring_sel_q1",  32'(bus.sel_idx),   32'd0);
            end
            if (i == 2) check("bring_sel_q2", 32'(bus.sel_idx), 32'd0);
            if (i == 3) begin
                check("bring_sel",    32'(bus.sel_idx), 32'd1);
                check("bring_online", 32'(bus.online),  32'd1);
            end
            if (i == 10) check("bring_sw_last", 32'(bus.switching), 32'd1);
            if (i == 11) check("bring_sw_fall", 32'(bus.switching), 32'd0);
            tick(i < 30);
        end

        // Over-rate: 98 edges land in one window and must saturate, not wrap.
        run_win(WIN_CYCLES);
        check("over_valid", 32'(bus.src_valid), 32'h1);
        sw_cycles = 0;
        run_win(30);
        check("over_sw_len", 32'(sw_cycles),     32'd10);
        check("over_sel",    32'(bus.sel_idx),   32'd0);
        check("over_online", 32'(bus.online),    32'd0);
        check("over_req1",   32'(bus.src_valid), 32'h1);
        run_win(30);
        check("over_req2",   32'(bus.src_valid), 32'h1);
        run_win(30);
        check("over_req3",   32'(bus.src_valid), 32'h3);
        sw_cycles = 0;
        run_win(30);
        check("over_back_sw",  32'(sw_cycles),   32'd10);
        check("over_back_sel", 32'(bus.sel_idx), 32'd1);

        // Loss: one under-rate window clears valid and forces a return to 0.
        run_win(5);
        check("loss_valid",   32'(bus.src_valid), 32'h1);
        check("loss_sel_old", 32'(bus.sel_idx),   32'd1);
        sw_cycles = 0;
        run_win(30);
        check("loss_sw_len", 32'(sw_cycles),   32'd10);
        check("loss_sel",    32'(bus.sel_idx), 32'd0);
        check("loss_online", 32'(bus.online),  32'd0);
        run_win(30);
        run_win(30);
        check("loss_requal", 32'(bus.src_valid), 32'h3);
        sw_cycles = 0;
        run_win(30);
        check("loss_back_sel", 32'(bus.sel_idx), 32'd1);
        check("loss_back_sw",  32'(sw_cycles),   32'd10);

        // Force to 0, then an out-of-range index, then release.
        bus.force_en  = 1'b1;
        bus.force_sel = 2'd0;
        sw_cycles = 0;
        run_win(30);
        check("force0_sel",    32'(bus.sel_idx),   32'd0);
        check("force0_online", 32'(bus.online),    32'd0);
        check("force0_sw",     32'(sw_cycles),     32'd10);
        check("force0_valid",  32'(bus.src_valid), 32'h3);
        bus.force_sel = 2'd3;
        sw_cycles = 0;
        run_win(30);
        check("force3_sel", 32'(bus.sel_idx), 32'd0);
        check("force3_sw",  32'(sw_cycles),   32'd0);

        // Release force; assert reset in the middle of the resulting SETTLE.
        bus.force_en  = 1'b0;
        bus.force_sel = 2'd0;
        for (int i = 0; i < 5; i++) tick(1'b1);
        check("pre_rst_sel", 32'(bus.sel_idx),   32'd1);
        check("pre_rst_sw",  32'(bus.switching), 32'd1);
        rst = 1'b1;
        #1;
        check("mid_rst_sel",    32'(bus.sel_idx),   32'd0);
        check("mid_rst_online", 32'(bus.online),    32'd0);
        check("mid_rst_sw",     32'(bus.switching), 32'd0);
        check("mid_rst_valid",  32'(bus.src_valid), 32'h1);
        @(negedge clk);
        rst = 1'b0;

        run_win(30);
        check("requal_1", 32'(bus.src_valid), 32'h1);
        run_win(30);
        check("requal_2", 32'(bus.src_valid), 32'h1);
        run_win(30);
        check("requal_3", 32'(bus.src_valid), 32'h3);
        sw_cycles = 0;
        run_win(30);
        check("requal_sel",    32'(bus.sel_idx), 32'd1);
        check("requal_online", 32'(bus.online),  32'd1);
        check("requal_sw",     32'(sw_cycles),   32'd10);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end
endmodule
